mux_sel_scheduler: RTL and testbench

- Upstream control stage for the registered 17-to-1 operand mux.
- Accepts a 16-bit lane-occupancy mask (one bit per mux input) and issues, one per cycle, the 5-bit select index of each set lane, lowest index first.
- Select value 16 is the mux's "zero" input and is issued once for an all-zero mask, so every mask produces at least one beat.
- Lets the downstream mux and accumulator skip zero lanes in bit-sparse operands.

---
 rtl/mux_sel_scheduler_pkg.sv | 10 +
 rtl/mux_sel_scheduler_prio_enc_16.sv | 28 ++
 rtl/mux_sel_scheduler.sv | 76 +++++++
 tb/tb_mux_sel_scheduler.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux_sel_scheduler_pkg.sv
// Shared constants and state type for the operand-mux select scheduler.
package mux_sched_pkg;
  localparam int NUM_LANES_C = 16;
  localparam logic [4:0] SEL_ZERO = 5'd16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_t;
endpackage

// File: rtl/mux_sel_scheduler_prio_enc_16.sv
// 16-bit priority encoder: index of the lowest set bit (highest when
// MUX_SEL_SCHED_MSB_FIRST_EN is defined), SEL_ZERO for an all-zero input.
module prio_enc_16
  import mux_sched_pkg::*;
(
  input  logic [NUM_LANES_C-1:0] i_vec,
  output logic [4:0]             o_idx,
  output logic                   o_le_one
);

  always_comb begin
    o_idx = SEL_ZERO;
`ifdef MUX_SEL_SCHED_MSB_FIRST_EN
    // Ascending scan: the last hit wins, so the highest set bit is reported.
    for (int i = 0; i < NUM_LANES_C; i++) begin
      if (i_vec[i]) o_idx = 5'(i);
    end
`else
    // Descending scan: the last hit wins, so the lowest set bit is reported.
    for (int i = NUM_LANES_C - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = 5'(i);
    end
`endif
  end

  assign o_le_one = ((i_vec & (i_vec - 16'd1)) == '0);

endmodule

// File: rtl/mux_sel_scheduler.sv
// Issues one mux select per set lane of an occupancy mask (select 16 once for
// an empty mask). MUX_SEL_SCHED_MSB_FIRST_EN switches to highest-lane-first.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both high.
// Once sel_valid rises it stays high, with sel/sel_last/beat_idx stable,
// until sel_ready accepts the beat. mask is only sampled on its accept cycle.
module mux_sel_scheduler
  import mux_sched_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int SEL_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] mask,
  input  logic                 mask_valid,
  output logic                 mask_ready,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 sel_valid,
  input  logic                 sel_ready,
  output logic                 sel_last,
  output logic [SEL_WIDTH-1:0] beat_idx,
  output sched_state_t         dbg_state
);

  sched_state_t         r_state;
  logic [NUM_LANES-1:0] r_work;
  logic [SEL_WIDTH-1:0] r_beat_cnt;

  logic [4:0] w_idx;
  logic       w_le_one;
  logic       w_issue;
  logic       w_fire;
  logic       w_accept;

  prio_enc_16 u_prio_enc (
    .i_vec    (r_work),
    .o_idx    (w_idx),
    .o_le_one (w_le_one)
  );

  // Outputs decode from registered state only; no input reaches them.
  assign w_issue   = (r_state == ISSUE);
  assign sel_valid = w_issue;
  assign sel       = w_issue ? w_idx : SEL_ZERO;
  assign sel_last  = w_issue & w_le_one;
  assign beat_idx  = w_issue ? r_beat_cnt : '0;
  assign dbg_state = r_state;

  assign w_fire     = sel_valid & sel_ready;
  assign mask_ready = (r_state == IDLE) | (w_fire & sel_last);
  assign w_accept   = mask_valid & mask_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_work     <= '0;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      // A new mask on the last-beat cycle overrides the return to IDLE.
      r_state    <= ISSUE;
      r_work     <= mask;
      r_beat_cnt <= '0;
    end else if (w_fire) begin
      if (sel_last) begin
        r_state <= IDLE;
        r_work  <= '0;
      end else begin
        // Not last implies work is nonzero, so w_idx names a real lane.
        r_work     <= r_work & ~(16'd1 << w_idx[3:0]);
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Bench for mux_sel_scheduler: directed scenarios plus random traffic against
// a queue-of-beats reference model.
module tb_mux_sel_scheduler;
  import mux_sched_pkg::*;

  logic         clk;
  logic         reset;
  logic [15:0]  mask;
  logic         mask_valid;
  logic         mask_ready;
  logic [4:0]   sel;
  logic         sel_valid;
  logic         sel_ready;
  logic         sel_last;
  logic [4:0]   beat_idx;
  sched_state_t dbg_state;

  int total = 0;
  int bad   = 0;

  // Each entry: {sel[4:0], last, beat_idx[4:0]} for a beat still to be issued.
  logic [10:0] exp_q[$];

  mux_sel_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .mask       (mask),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel_last   (sel_last),
    .beat_idx   (beat_idx),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected beat list for a mask, straight from the issue-order rule.
  task automatic push_beats(input logic [15:0] m);
    int lanes[$];
    for (int i = 0; i < 16; i++) if (m[i]) lanes.push_back(i);
`ifdef MUX_SEL_SCHED_MSB_FIRST_EN
    lanes.reverse();
`endif
    if (lanes.size() == 0) lanes.push_back(16);
    for (int b = 0; b < lanes.size(); b++)
      exp_q.push_back({5'(lanes[b]), (b == lanes.size() - 1), 5'(b)});
  endtask

  // One clock: drive inputs at negedge, compare, update model, advance.
  task automatic cycle(input logic mv, input logic [15:0] m, input logic rdy);
    logic        mrdy;
    logic [10:0] h;
    mask_valid = mv;
    mask       = m;
    sel_ready  = rdy;
    #1;
    mrdy = (exp_q.size() == 0) || (rdy && exp_q.size() == 1);
    check("mask_ready", mask_ready, mrdy);
    check("sel_valid", sel_valid, exp_q.size() > 0);
    check("state", dbg_state, (exp_q.size() > 0) ? ISSUE : IDLE);
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      check("sel", sel, h[10:6]);
      check("sel_last", sel_last, h[5]);
      check("beat_idx", beat_idx, h[4:0]);
    end else begin
      check("idle_sel", sel, 16);
      check("idle_last", sel_last, 0);
      check("idle_idx", beat_idx, 0);
    end
    if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
    if (mv && mrdy) push_beats(m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset      = 1'b1;
    mask_valid = 1'b1;
    mask       = 16'h0F0F;
    sel_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    reset      = 1'b1;
    mask       = '0;
    mask_valid = 1'b0;
    sel_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel_valid", sel_valid, 0);
    check("rst_sel", sel, 16);
    check("rst_mask_ready", mask_ready, 1);
    check("rst_sel_last", sel_last, 0);
    check("rst_beat_idx", beat_idx, 0);
    reset = 1'b0;

    // Sparse mask, downstream always ready.
    cycle(1, 16'h00A4, 1);
    repeat (4) cycle(0, 16'h0, 1);

    // Empty mask.
    cycle(1, 16'h0000, 1);
    repeat (2) cycle(0, 16'h0, 1);

    // Stall on the first beat.
    cycle(1, 16'h8001, 0);
    repeat (3) cycle(0, 16'hFFFF, 0);
    repeat (3) cycle(0, 16'h0, 1);

    // Back-to-back masks, second held valid while the first drains.
    cycle(1, 16'h0003, 1);
    cycle(1, 16'h0010, 1);
    cycle(1, 16'h0010, 1);
    repeat (2) cycle(0, 16'h0, 1);

    // Reset in the middle of a full mask.
    cycle(1, 16'hFFFF, 1);
    repeat (4) cycle(0, 16'h0, 1);
    reset_pulse();
    cycle(1, 16'h0002, 1);
    repeat (2) cycle(0, 16'h0, 1);

    // Full mask to the end, with a ready gap near the tail.
    cycle(1, 16'hFFFF, 1);
    repeat (14) cycle(0, 16'h0, 1);
    cycle(0, 16'h0, 0);
    repeat (3) cycle(0, 16'h0, 1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] m;
      case ($urandom_range(0, 4))
        0: m = 16'h0000;
        1: m = 16'hFFFF;
        2: m = 16'(1 << $urandom_range(0, 15));
        default: m = 16'($urandom);
      endcase
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else cycle($urandom_range(0, 2) != 0, m, $urandom_range(0, 3) != 0);
    end
    repeat (20) cycle(0, 16'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
